// File: rtl/di_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : di_arb_pkg
//  Description : Shared types and constants for the two-host DI bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package di_arb_pkg;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // One-hot grant encodings presented on the grant port
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_H0   = 2'b01;
    localparam logic [1:0] GRANT_H1   = 2'b10;

endpackage : di_arb_pkg
`default_nettype wire

// File: rtl/di_req_capture.sv
`default_nettype none
// ============================================================================
//  Module      : di_req_capture
//  Description : Remembers a single-cycle read request pulse raised by a host
//                that does not currently own the bus, until it is granted.
//  Revision    : 1.0  initial release
// ============================================================================
module di_req_capture
(
    input  logic ifclk,
    input  logic resetb,
    input  logic read_req,
    input  logic granted,
    output logic pend
);

    logic r_pend;

    // Pending flag: set by a pulse while not owner, cleared once owner.
    // A pulse seen while already owner goes straight to the bus instead.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_pend <= 1'b0;
        end else if (granted) begin
            r_pend <= 1'b0;
        end else if (read_req) begin
            r_pend <= 1'b1;
        end
    end

    assign pend = r_pend;

endmodule : di_req_capture
`default_nettype wire

// File: rtl/di_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : di_host_arbiter
//  Description : Round-robin two-host arbiter for the DI register bus. Grants
//                whole transactions, muxes the owner's command to the slave,
//                gates slave responses back to the owner, and flags grants
//                held for too long.
//  Revision    : 1.0  initial release
// ============================================================================
module di_host_arbiter
    import di_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
)
(
    input  logic        ifclk,
    input  logic        resetb,
    // host 0
    input  logic [15:0] h0_term_addr,
    input  logic [31:0] h0_reg_addr,
    input  logic [31:0] h0_len,
    input  logic        h0_read_mode,
    input  logic        h0_read_req,
    input  logic        h0_read,
    input  logic        h0_write_mode,
    input  logic        h0_write,
    input  logic [31:0] h0_reg_datai,
    output logic        h0_read_rdy,
    output logic        h0_write_rdy,
    output logic [31:0] h0_reg_datao,
    output logic [15:0] h0_transfer_status,
    // host 1
    input  logic [15:0] h1_term_addr,
    input  logic [31:0] h1_reg_addr,
    input  logic [31:0] h1_len,
    input  logic        h1_read_mode,
    input  logic        h1_read_req,
    input  logic        h1_read,
    input  logic        h1_write_mode,
    input  logic        h1_write,
    input  logic [31:0] h1_reg_datai,
    output logic        h1_read_rdy,
    output logic        h1_write_rdy,
    output logic [31:0] h1_reg_datao,
    output logic [15:0] h1_transfer_status,
    // downstream slave
    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic [31:0] di_len,
    output logic        di_read_mode,
    output logic        di_read_req,
    output logic        di_read,
    output logic        di_write_mode,
    output logic        di_write,
    output logic [31:0] di_reg_datai,
    input  logic        di_read_rdy,
    input  logic        di_write_rdy,
    input  logic [31:0] di_reg_datao,
    input  logic [15:0] di_transfer_status,
    // status
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        timeout_clr
);

    localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       r_state;
    logic [1:0]       r_grant;
    logic             r_last_h1;      // 1: host 1 was served last, host 0 wins ties
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    logic             w_pend0;
    logic             w_pend1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_req0;
    logic             w_req1;
    logic             w_rel0;
    logic             w_rel1;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout_hit;

    assign w_gnt0 = r_grant[0];
    assign w_gnt1 = r_grant[1];

    di_req_capture u_cap0 (
        .ifclk    (ifclk),
        .resetb   (resetb),
        .read_req (h0_read_req),
        .granted  (w_gnt0),
        .pend     (w_pend0)
    );

    di_req_capture u_cap1 (
        .ifclk    (ifclk),
        .resetb   (resetb),
        .read_req (h1_read_req),
        .granted  (w_gnt1),
        .pend     (w_pend1)
    );

    assign w_req0 = h0_read_mode | h0_write_mode | h0_read_req | w_pend0;
    assign w_req1 = h1_read_mode | h1_write_mode | h1_read_req | w_pend1;

    // Owner may let go only once its transaction and any strobe are finished
    assign w_rel0 = !(h0_read_mode | h0_write_mode | w_pend0 | h0_read | h0_write);
    assign w_rel1 = !(h1_read_mode | h1_write_mode | w_pend1 | h1_read | h1_write);

    // Ownership FSM: grants go through IDLE, so an owner switch always has a gap
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_grant   <= GRANT_NONE;
            r_last_h1 <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 && (!w_req1 || r_last_h1)) begin
                        r_state <= GNT0;
                        r_grant <= GRANT_H0;
                    end else if (w_req1) begin
                        r_state <= GNT1;
                        r_grant <= GRANT_H1;
                    end
                end
                GNT0: begin
                    if (w_rel0) begin
                        r_state   <= IDLE;
                        r_grant   <= GRANT_NONE;
                        r_last_h1 <= 1'b0;
                    end
                end
                GNT1: begin
                    if (w_rel1) begin
                        r_state   <= IDLE;
                        r_grant   <= GRANT_NONE;
                        r_last_h1 <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GRANT_NONE;
                end
            endcase
        end
    end

    assign w_cnt_inc     = r_hold_cnt + 1'b1;
    // Fires on the edge that closes the TIMEOUT_CYCLES-th granted cycle
    assign w_timeout_hit = (r_grant != GRANT_NONE) && (TIMEOUT_CYCLES != 0) &&
                           (r_hold_cnt != '1) && (w_cnt_inc == c_timeout_cnt);

    // Hold counter and sticky timeout flag; grant is never revoked here
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_grant == GRANT_NONE) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != '1) begin
                r_hold_cnt <= w_cnt_inc;
            end
            if (timeout_clr) begin
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Command mux from the registered grant; no owner drives all zeros
    always_comb begin
        di_term_addr  = '0;
        di_reg_addr   = '0;
        di_len        = '0;
        di_read_mode  = 1'b0;
        di_read_req   = 1'b0;
        di_read       = 1'b0;
        di_write_mode = 1'b0;
        di_write      = 1'b0;
        di_reg_datai  = '0;
        if (r_grant == GRANT_H0) begin
            di_term_addr  = h0_term_addr;
            di_reg_addr   = h0_reg_addr;
            di_len        = h0_len;
            di_read_mode  = h0_read_mode;
            di_read_req   = h0_read_req | w_pend0;
            di_read       = h0_read;
            di_write_mode = h0_write_mode;
            di_write      = h0_write;
            di_reg_datai  = h0_reg_datai;
        end else if (r_grant == GRANT_H1) begin
            di_term_addr  = h1_term_addr;
            di_reg_addr   = h1_reg_addr;
            di_len        = h1_len;
            di_read_mode  = h1_read_mode;
            di_read_req   = h1_read_req | w_pend1;
            di_read       = h1_read;
            di_write_mode = h1_write_mode;
            di_write      = h1_write;
            di_reg_datai  = h1_reg_datai;
        end
    end

    assign h0_read_rdy        = w_gnt0 & di_read_rdy;
    assign h0_write_rdy       = w_gnt0 & di_write_rdy;
    assign h0_transfer_status = w_gnt0 ? di_transfer_status : 16'h0000;
    assign h0_reg_datao       = di_reg_datao;

    assign h1_read_rdy        = w_gnt1 & di_read_rdy;
    assign h1_write_rdy       = w_gnt1 & di_write_rdy;
    assign h1_transfer_status = w_gnt1 ? di_transfer_status : 16'h0000;
    assign h1_reg_datao       = di_reg_datao;

    assign grant       = r_grant;
    assign timeout_err = r_timeout;

endmodule : di_host_arbiter
`default_nettype wire
